mem_access_stage: RTL

MEM pipeline stage that consumes the EXE-stage result bundle (ALU result, forwarded rs2 data, funct3, rd address, memory and writeback control) and performs the data-memory access. It holds the EXE/MEM register, formats stores into byte lanes, and drives a request/ready/rvalid data-memory handshake. It sign- or zero-extends load data and registers the result into the MEM/WB bundle. It stalls the front of the pipeline while a memory access is outstanding, and provides the MEM-stage forwarding source (`MEM_rd_data`) that the EXE stage's forwarding muxes select with code 2'b10.

---
 rtl/mem_access_stage.sv | 305 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//
// MEM pipeline stage. Holds the EXE/MEM register ("M"), turns stores into
// byte-lane writes, runs the request/ready/rvalid data-memory handshake,
// extends load data and registers the result into the MEM/WB bundle. While
// a memory access is outstanding it stalls the front of the pipeline, and it
// supplies the MEM-stage forwarding source for the EXE forwarding muxes.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   ex_*                 EXE result bundle (valid, ALU result / byte address,
//                        store data, link value, funct3, rd, result select,
//                        memory and writeback control bits)
//   mem_stall            freezes PC, IF/ID and ID/EXE while M cannot retire
//   dm_req/we/be/addr/wdata   data-memory request (combinational from M)
//   dm_ready             request accepted this cycle
//   dm_rvalid, dm_rdata  read response
//   MEM_rd_data/rd_addr/reg_write/is_load   forwarding and hazard sources
//   wb_*                 registered MEM/WB bundle
//   misalign_err         one-cycle pulse for a misaligned access
// ---------------------------------------------------------------------------
module mem_access_stage #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [31:0]       ex_alu_out,
  input  logic [31:0]       ex_rs2_data,
  input  logic [31:0]       ex_pc_sel_out,
  input  logic [2:0]        ex_funct3,
  input  logic [4:0]        ex_rd_addr,
  input  logic [1:0]        ex_mem_rd_sel,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_gen_reg_write,
  input  logic              ex_fp_reg_write,
  input  logic              ex_wb_data_sel,
  output logic              mem_stall,
  output logic              dm_req,
  output logic              dm_we,
  output logic [3:0]        dm_be,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic              dm_ready,
  input  logic              dm_rvalid,
  input  logic [31:0]       dm_rdata,
  output logic [31:0]       MEM_rd_data,
  output logic [4:0]        MEM_rd_addr,
  output logic              MEM_reg_write,
  output logic              MEM_is_load,
  output logic              wb_valid,
  output logic [4:0]        wb_rd_addr,
  output logic [31:0]       wb_alu_data,
  output logic [31:0]       wb_load_data,
  output logic              wb_gen_reg_write,
  output logic              wb_fp_reg_write,
  output logic              wb_data_sel,
  output logic              misalign_err
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } stateT;

  stateT       state_q, state_d;

  logic        mValid_q;
  logic [31:0] mAluOut_q;
  logic [31:0] mRs2Data_q;
  logic [31:0] mPcSel_q;
  logic [2:0]  mFunct3_q;
  logic [4:0]  mRdAddr_q;
  logic [1:0]  mRdSel_q;
  logic        mMemRead_q;
  logic        mMemWrite_q;
  logic        mGenWe_q;
  logic        mFpWe_q;
  logic        mWbSel_q;

  logic        wbValid_q;
  logic [4:0]  wbRdAddr_q;
  logic [31:0] wbAluData_q;
  logic [31:0] wbLoadData_q;
  logic        wbGenWe_q;
  logic        wbFpWe_q;
  logic        wbDataSel_q;

  logic        memOp;
  logic        opLoad;
  logic        opStore;
  logic [1:0]  lane;
  logic        misalignCond;
  logic        misaligned;
  logic        reqValid;
  logic        complete;
  logic [3:0]  storeBe;
  logic [31:0] storeData;
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;
  logic [31:0] loadValue;
  logic [31:0] memRdData;

  // The EXE/MEM register simply follows the EXE bundle except while the
  // stage is stalled, in which case the instruction in M is frozen so the
  // memory request it drives stays stable until it retires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mValid_q    <= 1'b0;
      mAluOut_q   <= '0;
      mRs2Data_q  <= '0;
      mPcSel_q    <= '0;
      mFunct3_q   <= '0;
      mRdAddr_q   <= '0;
      mRdSel_q    <= '0;
      mMemRead_q  <= 1'b0;
      mMemWrite_q <= 1'b0;
      mGenWe_q    <= 1'b0;
      mFpWe_q     <= 1'b0;
      mWbSel_q    <= 1'b0;
    end else if (!mem_stall) begin
      mValid_q    <= ex_valid;
      mAluOut_q   <= ex_alu_out;
      mRs2Data_q  <= ex_rs2_data;
      mPcSel_q    <= ex_pc_sel_out;
      mFunct3_q   <= ex_funct3;
      mRdAddr_q   <= ex_rd_addr;
      mRdSel_q    <= ex_mem_rd_sel;
      mMemRead_q  <= ex_mem_read;
      mMemWrite_q <= ex_mem_write;
      mGenWe_q    <= ex_gen_reg_write;
      mFpWe_q     <= ex_fp_reg_write;
      mWbSel_q    <= ex_wb_data_sel;
    end
  end

  // Classify the instruction in M. When both memory bits are set the op is
  // handled as a load. Alignment rules differ between loads and stores:
  // funct3 101 is LHU for loads but has no halfword meaning for stores, so
  // a 101 store is a plain word write with no alignment check.
  always_comb begin
    opLoad       = mMemRead_q;
    opStore      = mMemWrite_q & ~mMemRead_q;
    memOp        = mValid_q & (mMemRead_q | mMemWrite_q);
    lane         = mAluOut_q[1:0];
    misalignCond = 1'b0;
    case (mFunct3_q)
      3'b001:  misalignCond = lane[0];
      3'b101:  misalignCond = opLoad & lane[0];
      3'b010:  misalignCond = (lane != 2'b00);
      default: misalignCond = 1'b0;
    endcase
    misaligned = memOp & misalignCond;
  end

  // Store lane formatting: the data is replicated across the word so the
  // byte enables alone pick which lane memory actually writes.
  always_comb begin
    storeBe   = 4'b1111;
    storeData = mRs2Data_q;
    case (mFunct3_q)
      3'b000: begin
        storeBe   = 4'b0001 << lane;
        storeData = {4{mRs2Data_q[7:0]}};
      end
      3'b001: begin
        storeBe   = lane[1] ? 4'b1100 : 4'b0011;
        storeData = {2{mRs2Data_q[15:0]}};
      end
      default: begin
        storeBe   = 4'b1111;
        storeData = mRs2Data_q;
      end
    endcase
  end

  // Load extraction: pick the addressed byte or halfword out of the read
  // word, then sign- or zero-extend according to funct3.
  always_comb begin
    loadByte = dm_rdata[7:0];
    case (lane)
      2'd0:    loadByte = dm_rdata[7:0];
      2'd1:    loadByte = dm_rdata[15:8];
      2'd2:    loadByte = dm_rdata[23:16];
      default: loadByte = dm_rdata[31:24];
    endcase
    loadHalf  = lane[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    loadValue = dm_rdata;
    case (mFunct3_q)
      3'b000:  loadValue = {{24{loadByte[7]}}, loadByte};
      3'b001:  loadValue = {{16{loadHalf[15]}}, loadHalf};
      3'b100:  loadValue = {24'b0, loadByte};
      3'b101:  loadValue = {16'b0, loadHalf};
      default: loadValue = dm_rdata;
    endcase
  end

  // Handshake FSM. In IDLE any aligned memory op in M is by construction
  // not yet issued, because M only advances on the cycle an op retires.
  // A store retires on accept; a load parks in WAIT until rvalid. Anything
  // that is not an aligned memory op retires in its first M cycle.
  always_comb begin
    state_d  = state_q;
    reqValid = 1'b0;
    complete = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (memOp && !misaligned) begin
          reqValid = 1'b1;
          complete = 1'b0;
          if (dm_ready) begin
            if (opLoad) begin
              state_d = ST_WAIT;
            end else begin
              complete = 1'b1;
            end
          end
        end
      end
      ST_WAIT: begin
        complete = dm_rvalid;
        if (dm_rvalid) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state register; reset always returns to IDLE so a response that
  // arrives after a reset in WAIT falls into IDLE and is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request fields come straight from M, so they cannot change while the
  // request waits for ready.
  always_comb begin
    dm_req    = reqValid;
    dm_we     = reqValid & opStore;
    dm_be     = storeBe;
    dm_addr   = mAluOut_q[ADDR_W+1:2];
    dm_wdata  = storeData;
    mem_stall = memOp & ~complete;
  end

  // Forwarding view of M. The result select picks the link value for
  // jumps; every other encoding forwards the ALU result.
  always_comb begin
    memRdData     = (mRdSel_q == 2'b01) ? mPcSel_q : mAluOut_q;
    MEM_rd_data   = memRdData;
    MEM_rd_addr   = mRdAddr_q;
    MEM_reg_write = mValid_q & mGenWe_q;
    MEM_is_load   = mValid_q & mMemRead_q;
    misalign_err  = misaligned;
  end

  // MEM/WB register. A retiring instruction loads the whole bundle; a
  // misaligned one retires with its register writes suppressed. On cycles
  // with nothing retiring only the valid and write enables drop, so the
  // data fields keep their last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbValid_q    <= 1'b0;
      wbRdAddr_q   <= '0;
      wbAluData_q  <= '0;
      wbLoadData_q <= '0;
      wbGenWe_q    <= 1'b0;
      wbFpWe_q     <= 1'b0;
      wbDataSel_q  <= 1'b0;
    end else if (complete) begin
      wbValid_q    <= mValid_q;
      wbRdAddr_q   <= mRdAddr_q;
      wbAluData_q  <= memRdData;
      wbLoadData_q <= loadValue;
      wbGenWe_q    <= mValid_q & mGenWe_q & ~misaligned;
      wbFpWe_q     <= mValid_q & mFpWe_q & ~misaligned;
      wbDataSel_q  <= mWbSel_q;
    end else begin
      wbValid_q <= 1'b0;
      wbGenWe_q <= 1'b0;
      wbFpWe_q  <= 1'b0;
    end
  end

  // Drive the registered bundle onto the ports.
  always_comb begin
    wb_valid         = wbValid_q;
    wb_rd_addr       = wbRdAddr_q;
    wb_alu_data      = wbAluData_q;
    wb_load_data     = wbLoadData_q;
    wb_gen_reg_write = wbGenWe_q;
    wb_fp_reg_write  = wbFpWe_q;
    wb_data_sel      = wbDataSel_q;
  end

endmodule
